// File: rtl/draw_rect_fill.sv
// Purpose: clipped rectangle fill engine (solid / XOR / checker / colour-key) driving a screen RMW interface.
// Latency: draw_en at edge N -> screen_start in cycle N+1; screen_done at edge M -> draw_done in cycle M+1.
// Backpressure: one command at a time; draw_en outside S_IDLE is dropped, never queued.
//
// Ports:
//   clock, resetn                  - clock, synchronous active-low reset
//   draw_en, mode, colour, colour2 - command request and pixel mode/colours
//   x_min, y_min, x_range, y_range - requested rectangle (clipped to the screen at acceptance)
//   busy, draw_done                - status: busy while drawing, one-cycle completion pulse
//   screen_start, screen_*_min/range - region request to the screen interface
//   screen_x, screen_y, old_screen_colour, screen_done - live pixel feed from the interface
//   new_screen_colour              - combinational pixel value to write back
module draw_rect_fill #(
    parameter int WIDTH         = 8,
    parameter int COLOUR_WIDTH  = 3,
    parameter int SCREEN_SIZE_X = 160,
    parameter int SCREEN_SIZE_Y = 120
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    draw_en,
    input  logic [1:0]              mode,
    input  logic [COLOUR_WIDTH-1:0] colour,
    input  logic [COLOUR_WIDTH-1:0] colour2,
    input  logic [WIDTH-1:0]        x_min,
    input  logic [WIDTH-1:0]        y_min,
    input  logic [WIDTH-1:0]        x_range,
    input  logic [WIDTH-1:0]        y_range,
    output logic                    busy,
    output logic                    draw_done,
    output logic                    screen_start,
    output logic [COLOUR_WIDTH-1:0] new_screen_colour,
    output logic [WIDTH-1:0]        screen_x_min,
    output logic [WIDTH-1:0]        screen_y_min,
    output logic [WIDTH-1:0]        screen_x_range,
    output logic [WIDTH-1:0]        screen_y_range,
    input  logic [WIDTH-1:0]        screen_x,
    input  logic [WIDTH-1:0]        screen_y,
    input  logic [COLOUR_WIDTH-1:0] old_screen_colour,
    input  logic                    screen_done
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DRAW, S_DONE} state_t;

    localparam logic [1:0] MODE_SOLID   = 2'b00;
    localparam logic [1:0] MODE_XOR     = 2'b01;
    localparam logic [1:0] MODE_CHECKER = 2'b10;

    // One extra bit so the room left to the screen edge never wraps.
    localparam logic [WIDTH:0] LIM_X = (WIDTH+1)'(SCREEN_SIZE_X);
    localparam logic [WIDTH:0] LIM_Y = (WIDTH+1)'(SCREEN_SIZE_Y);

    state_t                  state;
    logic [1:0]              lat_mode;
    logic [COLOUR_WIDTH-1:0] lat_colour;
    logic [COLOUR_WIDTH-1:0] lat_colour2;

    logic [WIDTH:0]   x_avail;
    logic [WIDTH:0]   y_avail;
    logic [WIDTH-1:0] x_clip;
    logic [WIDTH-1:0] y_clip;
    logic             region_empty;

    always_comb begin
        x_avail      = LIM_X - {1'b0, x_min};
        y_avail      = LIM_Y - {1'b0, y_min};
        region_empty = ({1'b0, x_min} >= LIM_X) || ({1'b0, y_min} >= LIM_Y) ||
                       (x_range == '0) || (y_range == '0);
        // When the available room is the full 2^WIDTH span, x_range is always
        // smaller, so truncating the avail value never loses a taken result.
        x_clip = ({1'b0, x_range} < x_avail) ? x_range : x_avail[WIDTH-1:0];
        y_clip = ({1'b0, y_range} < y_avail) ? y_range : y_avail[WIDTH-1:0];
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            draw_done      <= 1'b0;
            screen_start   <= 1'b0;
            lat_mode       <= '0;
            lat_colour     <= '0;
            lat_colour2    <= '0;
            screen_x_min   <= '0;
            screen_y_min   <= '0;
            screen_x_range <= '0;
            screen_y_range <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    draw_done <= 1'b0;
                    if (draw_en) begin
                        lat_mode     <= mode;
                        lat_colour   <= colour;
                        lat_colour2  <= colour2;
                        screen_x_min <= x_min;
                        screen_y_min <= y_min;
                        if (region_empty) begin
                            // Empty region: skip the interface entirely.
                            screen_x_range <= '0;
                            screen_y_range <= '0;
                            state          <= S_DONE;
                            draw_done      <= 1'b1;
                        end else begin
                            screen_x_range <= x_clip;
                            screen_y_range <= y_clip;
                            state          <= S_START;
                            screen_start   <= 1'b1;
                            busy           <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    screen_start <= 1'b0;
                    state        <= S_DRAW;
                end
                S_DRAW: begin
                    if (screen_done) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        draw_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    draw_done <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state        <= S_IDLE;
                    busy         <= 1'b0;
                    draw_done    <= 1'b0;
                    screen_start <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        new_screen_colour = lat_colour;
        case (lat_mode)
            MODE_SOLID:   new_screen_colour = lat_colour;
            MODE_XOR:     new_screen_colour = old_screen_colour ^ lat_colour;
            MODE_CHECKER: new_screen_colour = (screen_x[0] ^ screen_y[0]) ? lat_colour2 : lat_colour;
            default:      new_screen_colour = (old_screen_colour == lat_colour2) ? lat_colour
                                                                                : old_screen_colour;
        endcase
    end

endmodule

// File: tb/tb_draw_rect_fill.sv
module tb_draw_rect_fill;

    localparam int SX = 160;
    localparam int SY = 120;

    logic       clock = 1'b0;
    logic       resetn;
    logic       draw_en;
    logic [1:0] mode;
    logic [2:0] colour, colour2;
    logic [7:0] x_min, y_min, x_range, y_range;
    logic       busy, draw_done, screen_start;
    logic [2:0] new_screen_colour;
    logic [7:0] screen_x_min, screen_y_min, screen_x_range, screen_y_range;
    logic [7:0] screen_x, screen_y;
    logic [2:0] old_screen_colour;
    logic       screen_done;

    int checks = 0;
    int errors = 0;

    draw_rect_fill #(.WIDTH(8), .COLOUR_WIDTH(3), .SCREEN_SIZE_X(SX), .SCREEN_SIZE_Y(SY)) dut (
        .clock(clock), .resetn(resetn), .draw_en(draw_en), .mode(mode),
        .colour(colour), .colour2(colour2),
        .x_min(x_min), .y_min(y_min), .x_range(x_range), .y_range(y_range),
        .busy(busy), .draw_done(draw_done), .screen_start(screen_start),
        .new_screen_colour(new_screen_colour),
        .screen_x_min(screen_x_min), .screen_y_min(screen_y_min),
        .screen_x_range(screen_x_range), .screen_y_range(screen_y_range),
        .screen_x(screen_x), .screen_y(screen_y),
        .old_screen_colour(old_screen_colour), .screen_done(screen_done)
    );

    always #5 clock = ~clock;

    // Reference: size of the visible part of a span, 0 when nothing is visible.
    function automatic int ref_range(input int mn, input int rg, input int lim);
        if (mn >= lim || rg == 0) return 0;
        return (rg < lim - mn) ? rg : lim - mn;
    endfunction

    // Reference pixel rule, expressed on plain integers.
    function automatic int ref_colour(input int m, input int c, input int c2,
                                      input int sx, input int sy, input int old);
        case (m)
            0: return c;
            1: return old ^ c;
            2: return (((sx + sy) % 2) == 0) ? c : c2;
            default: return (old == c2) ? c : old;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a command for exactly one edge, then scramble the command inputs.
    task automatic issue(input logic [1:0] m, input logic [2:0] c, input logic [2:0] c2,
                         input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] xr, input logic [7:0] yr);
        mode = m; colour = c; colour2 = c2;
        x_min = x; y_min = y; x_range = xr; y_range = yr;
        draw_en = 1'b1;
        tick();
        draw_en = 1'b0;
        mode = 2'($urandom); colour = 3'($urandom); colour2 = 3'($urandom);
        x_min = 8'($urandom); y_min = 8'($urandom);
        x_range = 8'($urandom); y_range = 8'($urandom);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, draw_done, screen_start} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got busy/done/start=%b want 000", {busy, draw_done, screen_start});
        end
        checks++;
        if ({screen_x_min, screen_y_min, screen_x_range, screen_y_range, new_screen_colour} !== 35'd0) begin
            errors++;
            $display("FAIL reset_region: got %0d/%0d/%0d/%0d col %0d want all 0",
                     screen_x_min, screen_y_min, screen_x_range, screen_y_range, new_screen_colour);
        end
        resetn = 1'b1;
        tick();
    endtask

    // One full command against the interface model: region, pixels, handshake timing.
    task automatic test_draw(input int m, input int c, input int c2, input int x, input int y,
                             input int xr, input int yr, input int npix);
        int exr, eyr;
        exr = ref_range(x, xr, SX);
        eyr = ref_range(y, yr, SY);
        issue(2'(m), 3'(c), 3'(c2), 8'(x), 8'(y), 8'(xr), 8'(yr));
        if (exr == 0 || eyr == 0) begin
            checks++;
            if ({draw_done, screen_start, busy} !== 3'b100) begin
                errors++;
                $display("FAIL draw_empty: done/start/busy=%b want 100 (x=%0d y=%0d xr=%0d yr=%0d)",
                         {draw_done, screen_start, busy}, x, y, xr, yr);
            end
            tick();
            checks++;
            if ({draw_done, screen_start} !== 2'b00) begin
                errors++;
                $display("FAIL draw_empty_after: done/start=%b want 00", {draw_done, screen_start});
            end
            return;
        end
        checks++;
        if ({screen_start, busy} !== 2'b11) begin
            errors++;
            $display("FAIL draw_start: start/busy=%b want 11", {screen_start, busy});
        end
        checks++;
        if (screen_x_min !== 8'(x) || screen_y_min !== 8'(y) ||
            screen_x_range !== 8'(exr) || screen_y_range !== 8'(eyr)) begin
            errors++;
            $display("FAIL draw_region: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                     screen_x_min, screen_y_min, screen_x_range, screen_y_range, x, y, exr, eyr);
        end
        tick();
        checks++;
        if ({screen_start, busy} !== 2'b01) begin
            errors++;
            $display("FAIL draw_start_pulse: start/busy=%b want 01", {screen_start, busy});
        end
        for (int i = 0; i < npix; i++) begin
            int sx, sy, old;
            sx = x + int'($urandom_range(0, exr - 1));
            sy = y + int'($urandom_range(0, eyr - 1));
            old = int'($urandom_range(0, 7));
            screen_x = 8'(sx); screen_y = 8'(sy); old_screen_colour = 3'(old);
            #1;
            checks++;
            if (new_screen_colour !== 3'(ref_colour(m, c, c2, sx, sy, old))) begin
                errors++;
                $display("FAIL draw_pixel: mode %0d (%0d,%0d) old %0d got %0d want %0d",
                         m, sx, sy, old, new_screen_colour, ref_colour(m, c, c2, sx, sy, old));
            end
            tick();
        end
        screen_done = 1'b1;
        tick();
        screen_done = 1'b0;
        checks++;
        if ({draw_done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL draw_done: done/busy=%b want 10", {draw_done, busy});
        end
        tick();
        checks++;
        if ({draw_done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL draw_done_pulse: done/busy=%b want 00", {draw_done, busy});
        end
    endtask

    task automatic test_clip();
        issue(2'd0, 3'd1, 3'd0, 8'd150, 8'd115, 8'd30, 8'd10);
        checks++;
        if (screen_x_range !== 8'd10 || screen_y_range !== 8'd5 || screen_start !== 1'b1) begin
            errors++;
            $display("FAIL clip_edge: got xr=%0d yr=%0d start=%b want 10 5 1",
                     screen_x_range, screen_y_range, screen_start);
        end
        tick();
        screen_done = 1'b1;
        tick();
        screen_done = 1'b0;
        tick();
        // Off-screen origin and zero range: immediate done, interface untouched.
        for (int k = 0; k < 2; k++) begin
            int starts = 0;
            if (k == 0) issue(2'd0, 3'd1, 3'd0, 8'd160, 8'd10, 8'd5, 8'd5);
            else        issue(2'd0, 3'd1, 3'd0, 8'd10, 8'd10, 8'd0, 8'd5);
            checks++;
            if (draw_done !== 1'b1) begin
                errors++;
                $display("FAIL clip_empty_done[%0d]: got %b want 1", k, draw_done);
            end
            for (int j = 0; j < 4; j++) begin
                if (screen_start === 1'b1) starts++;
                tick();
            end
            checks++;
            if (starts != 0) begin
                errors++;
                $display("FAIL clip_empty_start[%0d]: got %0d start cycles want 0", k, starts);
            end
        end
    endtask

    task automatic test_modes();
        int exp_tab[6] = '{3, 5, 2, 5, 7, 5};
        int mtab[6]    = '{1, 2, 2, 3, 3, 0};
        int xtab[6]    = '{0, 4, 5, 0, 0, 0};
        int otab[6]    = '{6, 0, 0, 2, 7, 1};
        for (int i = 0; i < 6; i++) begin
            issue(2'(mtab[i]), 3'd5, 3'd2, 8'd0, 8'd0, 8'd10, 8'd10);
            screen_x = 8'(xtab[i]); screen_y = 8'd6; old_screen_colour = 3'(otab[i]);
            #1;
            checks++;
            if (new_screen_colour !== 3'(exp_tab[i])) begin
                errors++;
                $display("FAIL mode[%0d]: mode %0d got %0d want %0d", i, mtab[i], new_screen_colour, exp_tab[i]);
            end
            tick();
            screen_done = 1'b1;
            tick();
            screen_done = 1'b0;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        issue(2'd0, 3'd1, 3'd0, 8'd10, 8'd12, 8'd4, 8'd3);
        // In S_START: early screen_done and a competing command.
        screen_done = 1'b1;
        mode = 2'd1; colour = 3'd6; x_min = 8'd40; y_min = 8'd50; x_range = 8'd9; y_range = 8'd9;
        draw_en = 1'b1;
        tick();
        screen_done = 1'b0;
        checks++;
        if ({draw_done, busy} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_early_done: done/busy=%b want 01", {draw_done, busy});
        end
        tick();
        tick();
        old_screen_colour = 3'd4;
        #1;
        checks++;
        if (screen_x_min !== 8'd10 || screen_y_min !== 8'd12 || screen_x_range !== 8'd4 ||
            screen_y_range !== 8'd3 || new_screen_colour !== 3'd1) begin
            errors++;
            $display("FAIL b2b_kept: got %0d/%0d/%0d/%0d col %0d want 10/12/4/3 col 1",
                     screen_x_min, screen_y_min, screen_x_range, screen_y_range, new_screen_colour);
        end
        draw_en = 1'b0;
        screen_done = 1'b1;
        tick();
        screen_done = 1'b0;
        if (draw_done === 1'b1) dones++;
        // draw_en during S_DONE must be dropped too.
        draw_en = 1'b1;
        tick();
        draw_en = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (draw_done === 1'b1) dones++;
            checks++;
            if ({busy, screen_start} !== 2'b00) begin
                errors++;
                $display("FAIL b2b_idle[%0d]: busy/start=%b want 00", j, {busy, screen_start});
            end
            tick();
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d want 1", dones);
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        issue(2'd1, 3'd7, 3'd3, 8'd20, 8'd20, 8'd8, 8'd8);
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        old_screen_colour = 3'd5;
        #1;
        checks++;
        if ({busy, draw_done, screen_start} !== 3'b000 ||
            {screen_x_min, screen_y_min, screen_x_range, screen_y_range, new_screen_colour} !== 35'd0) begin
            errors++;
            $display("FAIL reset_mid: flags=%b region %0d/%0d/%0d/%0d col %0d want all 0",
                     {busy, draw_done, screen_start}, screen_x_min, screen_y_min,
                     screen_x_range, screen_y_range, new_screen_colour);
        end
        screen_done = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (draw_done === 1'b1) dones++;
        end
        screen_done = 1'b0;
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset_mid_done: got %0d draw_done cycles want 0", dones);
        end
        test_draw(2, 6, 1, 30, 40, 5, 5, 3);
    endtask

    task automatic test_full_screen();
        issue(2'd0, 3'd0, 3'd0, 8'd0, 8'd0, 8'd160, 8'd120);
        checks++;
        if (screen_start !== 1'b1 || screen_x_range !== 8'd160 || screen_y_range !== 8'd120) begin
            errors++;
            $display("FAIL full_start: start=%b xr=%0d yr=%0d want 1 160 120",
                     screen_start, screen_x_range, screen_y_range);
        end
        tick();
        screen_x = 8'd159; screen_y = 8'd119; old_screen_colour = 3'd7;
        #1;
        checks++;
        if (new_screen_colour !== 3'd0) begin
            errors++;
            $display("FAIL full_pixel: got %0d want 0", new_screen_colour);
        end
        tick();
        screen_done = 1'b1;
        tick();
        screen_done = 1'b0;
        checks++;
        if (draw_done !== 1'b1) begin
            errors++;
            $display("FAIL full_done: got %b want 1", draw_done);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            test_draw(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 170)), int'($urandom_range(0, 130)),
                      int'($urandom_range(0, 60)), int'($urandom_range(0, 60)), 4);
        end
    endtask

    initial begin
        resetn = 1'b0; draw_en = 1'b0; mode = '0; colour = '0; colour2 = '0;
        x_min = '0; y_min = '0; x_range = '0; y_range = '0;
        screen_x = '0; screen_y = '0; old_screen_colour = '0; screen_done = 1'b0;
        test_reset();
        test_draw(0, 3, 0, 10, 20, 5, 4, 6);
        test_clip();
        test_modes();
        test_back_to_back();
        test_reset_mid();
        test_full_screen();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
